// File: rtl/bin2bcd_disp.sv
// Sequential binary-to-BCD converter (double dabble) feeding an 8-digit display register.
// Define BCD_SAT_EN to show 9999_9999 instead of EEEE_EEEE on overflow.
module bin2bcd_disp #(
    parameter int unsigned BIN_W = 27
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [31:0]      disp_data,
    output logic             en
);

    localparam int unsigned CntW = $clog2(BIN_W + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(BIN_W - 1);

`ifdef BCD_SAT_EN
    localparam logic [31:0] OvfPattern = 32'h9999_9999;
`else
    localparam logic [31:0] OvfPattern = 32'hEEEE_EEEE;
`endif

    typedef enum logic [1:0] {
        StIdle,
        StConv,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [BIN_W-1:0] bin_sr_q, bin_sr_d;
    logic [31:0]      bcd_q, bcd_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             ovf_pend_q, ovf_pend_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;
    logic [31:0]      disp_q, disp_d;
    logic             en_q, en_d;

    logic [31:0]      bcd_adj;
    logic             ovf_cmp;

    assign ovf_cmp = (32'(bin) > 32'd99_999_999);

    // Add-3 correction so each nibble stays a valid decimal digit after the shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 8; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        bin_sr_d   = bin_sr_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        done_d     = 1'b0;
        ovf_d      = ovf_q;
        disp_d     = disp_q;
        en_d       = en_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    bin_sr_d   = bin;
                    bcd_d      = 32'h0000_0000;
                    cnt_d      = '0;
                    ovf_pend_d = ovf_cmp;
                    state_d    = StConv;
                end
            end
            StConv: begin
                bcd_d    = {bcd_adj[30:0], bin_sr_q[BIN_W-1]};
                bin_sr_d = bin_sr_q << 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                disp_d  = ovf_pend_q ? OvfPattern : bcd_q;
                ovf_d   = ovf_pend_q;
                done_d  = 1'b1;
                en_d    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            bin_sr_q   <= '0;
            bcd_q      <= 32'h0000_0000;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            disp_q     <= 32'h0000_0000;
            en_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_sr_q   <= bin_sr_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            disp_q     <= disp_d;
            en_q       <= en_d;
        end
    end

    assign busy      = (state_q != StIdle);
    assign done      = done_q;
    assign ovf       = ovf_q;
    assign disp_data = disp_q;
    assign en        = en_q;

endmodule

// File: tb/tb_bin2bcd_disp.sv
// Scoreboard bench for bin2bcd_disp: stimulus pushes model results, a negedge monitor
// pops and checks value, overflow flag, latency and hold-stability of the display.
`timescale 1ns/1ps
module tb_bin2bcd_disp;

    localparam int unsigned BIN_W = 27;
    localparam int unsigned LAT   = BIN_W + 1;
`ifdef BCD_SAT_EN
    localparam logic [31:0] SAT_PAT = 32'h9999_9999;
`else
    localparam logic [31:0] SAT_PAT = 32'hEEEE_EEEE;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [BIN_W-1:0] bin;
    logic             busy;
    logic             done;
    logic             ovf;
    logic [31:0]      disp_data;
    logic             en;

    bin2bcd_disp #(.BIN_W(BIN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bin       (bin),
        .busy      (busy),
        .done      (done),
        .ovf       (ovf),
        .disp_data (disp_data),
        .en        (en)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;

    logic [32:0]     exp_q[$];
    longint unsigned t_q[$];
    logic [32:0]     mon_exp;
    longint unsigned mon_t;
    logic [31:0]     hold_disp = 32'h0;
    logic            hold_ovf  = 1'b0;

    // Reference: decimal digits by division; out-of-range values map to the overflow pattern.
    function automatic logic [32:0] model(input longint unsigned v);
        logic [31:0] r;
        longint unsigned x;
        r = 32'h0;
        x = v;
        if (v > 64'd99_999_999) return {1'b1, SAT_PAT};
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return {1'b0, r};
    endfunction

    task automatic check(input string name, input longint unsigned act,
                         input longint unsigned req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            hold_disp = 32'h0;
            hold_ovf  = 1'b0;
        end else if (done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected none at %0t", $time);
            end else begin
                mon_exp = exp_q.pop_front();
                mon_t   = t_q.pop_front();
                check("disp_data", disp_data, mon_exp[31:0]);
                check("ovf", ovf, mon_exp[32]);
                check("latency", ($time - 5 - mon_t) / 10, LAT);
                check("en_after_done", en, 1);
                hold_disp = mon_exp[31:0];
                hold_ovf  = mon_exp[32];
            end
        end else begin
            check("hold_disp", disp_data, hold_disp);
            check("hold_ovf", ovf, hold_ovf);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input longint unsigned v, input bit expect_done);
        bin   = BIN_W'(v);
        start = 1'b1;
        @(posedge clk);
        if (expect_done) begin
            exp_q.push_back(model(v));
            t_q.push_back($time);
        end
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 100; i++) begin
            tick();
            if (done) return;
        end
        total++;
        bad++;
        $display("FAIL wait_done: got no done expected done within 100 cycles");
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0) return;
            tick();
        end
        total++;
        bad++;
        $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    int base_cnt;
    longint unsigned v;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        bin   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ovf", ovf, 0);
        check("rst_en", en, 0);
        check("rst_disp", disp_data, 0);
        rst = 1'b0;
        tick();

        issue(12_345_678, 1'b1);
        check("busy_in_conv", busy, 1);
        drain();
        tick();
        check("en_set", en, 1);
        check("busy_idle", busy, 0);

        // Back-to-back, second start issued in the done cycle.
        issue(0, 1'b1);
        wait_done();
        issue(99_999_999, 1'b1);
        drain();
        tick();

        issue(100_000_000, 1'b1);
        wait_done();
        issue(42, 1'b1);
        drain();
        tick();

        // Starts while busy are ignored.
        base_cnt = done_cnt;
        issue(1_234, 1'b1);
        repeat (4) tick();
        issue(7_777, 1'b0);
        repeat (9) tick();
        issue(5_555, 1'b0);
        drain();
        repeat (40) tick();
        check("ignored_start_dones", done_cnt - base_cnt, 1);

        // Reset during the 10th conversion cycle.
        base_cnt = done_cnt;
        issue(87_654_321, 1'b0);
        repeat (9) tick();
        check("busy_before_rst", busy, 1);
        rst = 1'b1;
        tick();
        check("abort_busy", busy, 0);
        check("abort_en", en, 0);
        check("abort_disp", disp_data, 0);
        check("abort_done", done, 0);
        rst = 1'b0;
        repeat (40) tick();
        check("abort_no_done", done_cnt - base_cnt, 0);

        // Randomized back-to-back conversions.
        for (int i = 0; i < 30; i++) begin
            if (i % 3 == 0) v = longint'($urandom_range(32'd134_217_727, 32'd0));
            else            v = longint'($urandom_range(32'd99_999_999, 32'd0));
            issue(v, 1'b1);
            if (i % 2 == 0) wait_done();
            else            drain();
        end
        drain();
        repeat (5) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bin2bcd_disp.md
BIN2BCD_DISP -- requirements
Module: bin2bcd_disp

Interface
REQ-001 SHALL have parameter: BIN_W, 27, binary input width; legal range 1..27.
REQ-002 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: start  input  1  single-cycle conversion request.
REQ-005 SHALL have port: bin  input  BIN_W  unsigned binary value, sampled with start.
REQ-006 SHALL have port: busy  output  1  conversion in progress.
REQ-007 SHALL have port: done  output  1  one-cycle pulse, result valid.
REQ-008 SHALL have port: ovf  output  1  last sampled value exceeded 99_999_999.
REQ-009 SHALL have port: disp_data  output  32  eight packed BCD digits; digit 0 in [3:0], digit 7 in [31:28].
REQ-010 SHALL have port: en  output  1  display scan enable for the downstream 8-digit tube driver.
REQ-011 SHALL use one clock and a synchronous, active-high reset (clk, rst).

Function
REQ-012 SHALL implement FSM IDLE -> CONV -> DONE -> IDLE.
REQ-013 SHALL, in IDLE with start=1, capture bin into a shift register, clear the 32-bit BCD accumulator, latch the overflow compare, and enter CONV.
REQ-014 SHALL, in CONV, per cycle: add 3 to each BCD nibble >= 5, then shift {bcd, bin_sr} left by one; after exactly BIN_W shifts enter DONE.
REQ-015 SHALL, in DONE, register the result into disp_data and ovf, pulse done for exactly one cycle, return to IDLE.
REQ-016 SHALL rise done exactly BIN_W+1 clock edges after the edge that sampled start (28 for default); disp_data and ovf update on that same edge.
REQ-017 SHALL hold busy=1 in CONV and DONE, 0 in IDLE.
REQ-018 SHALL ignore start while busy=1; no queuing, no effect on the running conversion.
REQ-019 SHALL accept start in the same cycle done is high (FSM is then IDLE on next edge only); back-to-back throughput is one conversion per BIN_W+2 cycles.
REQ-020 SHALL hold disp_data and ovf stable between done pulses.
REQ-021 SHALL set ovf when sampled bin > 99_999_999 (reachable only for BIN_W=27); ovf clears on the next completed in-range conversion.
REQ-022 SHALL, on overflow without the configuration macro, drive disp_data = 32'hEEEE_EEEE.
REQ-023 SHALL set en to 1 on the first done pulse after reset and keep it 1 until reset.
REQ-024 SHALL zero-extend bin internally; upper BCD digits for small BIN_W read 0.

Reset
REQ-025 SHALL on rst=1 force: FSM IDLE, busy=0, done=0, ovf=0, en=0, disp_data=32'h0000_0000, shift registers zero.
REQ-026 SHALL abort any conversion in progress on rst; no done pulse produced for the aborted request.
REQ-027 SHALL give rst priority over start in the same cycle.

Configuration
REQ-028 SHALL support macro BCD_SAT_EN.
REQ-029 SHALL, with BCD_SAT_EN defined, drive disp_data = 32'h9999_9999 on overflow (ovf still 1).
REQ-030 SHALL, without BCD_SAT_EN, drive disp_data = 32'hEEEE_EEEE on overflow; in-range behaviour identical in both builds.

Verification
REQ-031 SHALL cover: start with bin=12_345_678 -> done 28 edges later, disp_data=32'h1234_5678, ovf=0, en=1.
REQ-032 SHALL cover: bin=0 then bin=99_999_999 back-to-back -> 32'h0000_0000 then 32'h9999_9999, ovf=0 both.
REQ-033 SHALL cover: bin=100_000_000 -> ovf=1, disp_data=32'hEEEE_EEEE (32'h9999_9999 with BCD_SAT_EN); next bin=42 -> 32'h0000_0042, ovf=0.
REQ-034 SHALL cover: start pulses at cycles 5 and 15 after one accepted start -> exactly one done, result of first bin.
REQ-035 SHALL cover: rst asserted at 10th CONV cycle -> next edge busy=0, en=0, disp_data=0, no done.
REQ-036 SHALL cover: start asserted in the done cycle -> second conversion starts on next IDLE cycle and completes with correct value.
